// File: rtl/math_mul_seq_pkg.sv
// ============================================================================
// Module  : math_mul_seq_pkg
// Brief   : Shared types and helpers for the sequential digit-serial multiplier.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package math_mul_seq_pkg;

   localparam int unsigned DIGIT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   // Bit offset of digit position idx (or of a digit-pair weight i+j).
   function automatic int unsigned digit_shift(input int unsigned idx);
      return idx * DIGIT_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/math_multiplier_wallace_tree_csa_008.sv
// ============================================================================
// Module  : math_multiplier_wallace_tree_csa_008
// Brief   : 8x8 unsigned combinational multiplier, carry-save (Wallace) reduction.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module math_multiplier_wallace_tree_csa_008
   import math_mul_seq_pkg::*;
(
   input  logic [DIGIT_W-1:0]   i_multiplier,
   input  logic [DIGIT_W-1:0]   i_multiplicand,
   output logic [2*DIGIT_W-1:0] ow_product
);

   localparam int unsigned PW = 2 * DIGIT_W;

   function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x,
                                             input logic [PW-1:0] y,
                                             input logic [PW-1:0] z);
      return x ^ y ^ z;
   endfunction

   // The product fits in PW bits, so dropping the carry out of the top is safe.
   function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x,
                                               input logic [PW-1:0] y,
                                               input logic [PW-1:0] z);
      return ((x & y) | (x & z) | (y & z)) << 1;
   endfunction

   logic [PW-1:0] w_pp [DIGIT_W];

   for (genvar g = 0; g < DIGIT_W; g++) begin : g_pp
      assign w_pp[g] = i_multiplicand[g] ? ({{DIGIT_W{1'b0}}, i_multiplier} << g) : '0;
   end

   // 8 rows -> 6 -> 4 -> 3 -> 2 -> final carry-propagate add
   logic [PW-1:0] w_l1_s0, w_l1_c0, w_l1_s1, w_l1_c1;
   logic [PW-1:0] w_l2_s0, w_l2_c0, w_l2_s1, w_l2_c1;
   logic [PW-1:0] w_l3_s0, w_l3_c0;
   logic [PW-1:0] w_l4_s0, w_l4_c0;

   assign w_l1_s0 = csa_sum  (w_pp[0], w_pp[1], w_pp[2]);
   assign w_l1_c0 = csa_carry(w_pp[0], w_pp[1], w_pp[2]);
   assign w_l1_s1 = csa_sum  (w_pp[3], w_pp[4], w_pp[5]);
   assign w_l1_c1 = csa_carry(w_pp[3], w_pp[4], w_pp[5]);

   assign w_l2_s0 = csa_sum  (w_l1_s0, w_l1_c0, w_l1_s1);
   assign w_l2_c0 = csa_carry(w_l1_s0, w_l1_c0, w_l1_s1);
   assign w_l2_s1 = csa_sum  (w_l1_c1, w_pp[6], w_pp[7]);
   assign w_l2_c1 = csa_carry(w_l1_c1, w_pp[6], w_pp[7]);

   assign w_l3_s0 = csa_sum  (w_l2_s0, w_l2_c0, w_l2_s1);
   assign w_l3_c0 = csa_carry(w_l2_s0, w_l2_c0, w_l2_s1);

   assign w_l4_s0 = csa_sum  (w_l3_s0, w_l3_c0, w_l2_c1);
   assign w_l4_c0 = csa_carry(w_l3_s0, w_l3_c0, w_l2_c1);

   assign ow_product = w_l4_s0 + w_l4_c0;

endmodule

`default_nettype wire

// File: rtl/math_multiplier_wallace_seq_ctrl.sv
// ============================================================================
// Module  : math_multiplier_wallace_seq_ctrl
// Brief   : WIDTH x WIDTH unsigned multiplier time-sharing one 8x8 core, K*K cycles.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module math_multiplier_wallace_seq_ctrl
   import math_mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clear,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [WIDTH-1:0]   i_multiplier,
   input  logic [WIDTH-1:0]   i_multiplicand,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [2*WIDTH-1:0] o_product,
   output logic               o_busy
);

   localparam int unsigned K     = WIDTH / DIGIT_W;
   localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(K - 1);

   if ((WIDTH % DIGIT_W) != 0 || WIDTH < 16) begin : g_width_check
      $error("WIDTH must be a multiple of 8 and at least 16");
   end

   mul_state_t           state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     i_q, i_d;
   logic [CNT_W-1:0]     j_q, j_d;

   logic [DIGIT_W-1:0]   w_a_dig [K];
   logic [DIGIT_W-1:0]   w_b_dig [K];
   logic [2*DIGIT_W-1:0] w_core_prod;
   logic [2*WIDTH-1:0]   w_pp_ext;
   logic [2*WIDTH-1:0]   w_pp_shift;
   logic                 w_accept;

   for (genvar g = 0; g < K; g++) begin : g_digit
      assign w_a_dig[g] = a_q[g*DIGIT_W +: DIGIT_W];
      assign w_b_dig[g] = b_q[g*DIGIT_W +: DIGIT_W];
   end

   math_multiplier_wallace_tree_csa_008 u_core (
      .i_multiplier   (w_a_dig[i_q]),
      .i_multiplicand (w_b_dig[j_q]),
      .ow_product     (w_core_prod)
   );

   assign w_pp_ext   = {{(2*WIDTH-2*DIGIT_W){1'b0}}, w_core_prod};
   assign w_pp_shift = w_pp_ext << digit_shift(32'(i_q) + 32'(j_q));

   assign o_ready   = (state_q == IDLE) || ((state_q == DONE) && i_ready);
   assign w_accept  = i_valid && o_ready;
   assign o_valid   = (state_q == DONE);
   assign o_busy    = (state_q == MUL);
   assign o_product = acc_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (w_accept) begin
               a_d     = i_multiplier;
               b_d     = i_multiplicand;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = MUL;
            end else if (state_q == DONE && i_ready) begin
               state_d = IDLE;
            end
         end
         MUL: begin
            acc_d = acc_q + w_pp_shift;
            if (j_q == C_LAST_IDX) begin
               j_d = '0;
               if (i_q == C_LAST_IDX) begin
                  i_d     = '0;
                  state_d = DONE;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort outranks any handshake, including a same-edge accept.
      if (i_clear) begin
         state_d = IDLE;
         acc_d   = '0;
         i_d     = '0;
         j_d     = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_math_multiplier_wallace_seq_ctrl.sv
// ============================================================================
// Module  : tb_math_multiplier_wallace_seq_ctrl
// Brief   : Directed-vector bench for the sequential multiplier (WIDTH 16 and 32).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_math_multiplier_wallace_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        valid;
   logic        ready_o;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic        valid_o;
   logic        ready;
   logic [31:0] prod;
   logic        busy;

   logic        w32_clear;
   logic        w32_valid;
   logic        w32_ready_o;
   logic [31:0] w32_a;
   logic [31:0] w32_b;
   logic        w32_valid_o;
   logic        w32_ready;
   logic [63:0] w32_prod;
   logic        w32_busy;

   int n_checks = 0;
   int n_pass   = 0;

   math_multiplier_wallace_seq_ctrl #(.WIDTH(16)) u_dut16 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_clear        (clear),
      .i_valid        (valid),
      .o_ready        (ready_o),
      .i_multiplier   (mul_a),
      .i_multiplicand (mul_b),
      .o_valid        (valid_o),
      .i_ready        (ready),
      .o_product      (prod),
      .o_busy         (busy)
   );

   math_multiplier_wallace_seq_ctrl #(.WIDTH(32)) u_dut32 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_clear        (w32_clear),
      .i_valid        (w32_valid),
      .o_ready        (w32_ready_o),
      .i_multiplier   (w32_a),
      .i_multiplicand (w32_b),
      .o_valid        (w32_valid_o),
      .i_ready        (w32_ready),
      .o_product      (w32_prod),
      .o_busy         (w32_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles until o_valid on the 16-bit DUT; -1 if the bound expires.
   task automatic wait_valid(output int n);
      n = 0;
      while (!valid_o && n < 40) begin
         tick();
         n++;
      end
      if (!valid_o) n = -1;
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      mul_a = a;
      mul_b = b;
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      int n;
      int cnt;
      int busy_cnt;

      rst_n = 1'b0; clear = 1'b0; valid = 1'b0; ready = 1'b1;
      mul_a = '0; mul_b = '0;
      w32_clear = 1'b0; w32_valid = 1'b0; w32_ready = 1'b1;
      w32_a = '0; w32_b = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_busy",  64'(busy),    64'd0);
      chk("rst_prod",  64'(prod),    64'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", 64'(ready_o), 64'd1);

      // 1: basic product and latency
      issue(16'h1234, 16'h5678);
      chk("t1_busy",  64'(busy),    64'd1);
      chk("t1_ready", 64'(ready_o), 64'd0);
      wait_valid(n);
      chk("t1_lat",   64'(n),       64'd4);
      chk("t1_prod",  64'(prod),    64'h06260060);
      chk("t1_rdy_done", 64'(ready_o), 64'd1);
      tick();
      chk("t1_one_cycle", 64'(valid_o), 64'd0);
      chk("t1_prod_held", 64'(prod),    64'h06260060);

      // 2: stall in DONE with toggling inputs
      ready = 1'b0;
      issue(16'hFFFF, 16'hFFFF);
      wait_valid(n);
      chk("t2_lat", 64'(n), 64'd4);
      for (int k = 0; k < 10; k++) begin
         mul_a = 16'($urandom);
         mul_b = 16'($urandom);
         valid = k[0];
         tick();
         chk("t2_hold_valid", 64'(valid_o), 64'd1);
         chk("t2_hold_prod",  64'(prod),    64'hFFFE0001);
      end
      valid = 1'b0;
      ready = 1'b1;
      tick();
      chk("t2_idle_valid", 64'(valid_o), 64'd0);
      chk("t2_idle_busy",  64'(busy),    64'd0);
      chk("t2_idle_ready", 64'(ready_o), 64'd1);

      // 3: back-to-back handoff
      issue(16'h00FF, 16'h0100);
      wait_valid(n);
      chk("t3_lat1",  64'(n),    64'd4);
      chk("t3_prod1", 64'(prod), 64'h0000FF00);
      issue(16'd3, 16'd5);
      chk("t3_b2b_busy", 64'(busy), 64'd1);
      wait_valid(n);
      chk("t3_lat2",  64'(n + 1), 64'd5);
      chk("t3_prod2", 64'(prod),  64'h0000000F);
      tick();

      // 4: clear mid-MUL, then clear racing an accept
      issue(16'hABCD, 16'h1111);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t4_valid", 64'(valid_o), 64'd0);
      chk("t4_busy",  64'(busy),    64'd0);
      chk("t4_prod",  64'(prod),    64'd0);
      chk("t4_ready", 64'(ready_o), 64'd1);
      mul_a = 16'd7; mul_b = 16'd9; valid = 1'b1; clear = 1'b1;
      tick();
      valid = 1'b0; clear = 1'b0;
      chk("t4_clr_wins", 64'(busy), 64'd0);
      issue(16'd2, 16'd3);
      wait_valid(n);
      chk("t4_lat",  64'(n),    64'd4);
      chk("t4_prod", 64'(prod), 64'd6);
      tick();

      // 5: async reset mid-MUL
      issue(16'h1234, 16'h5678);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy",  64'(busy),    64'd0);
      chk("t5_rst_valid", 64'(valid_o), 64'd0);
      chk("t5_rst_prod",  64'(prod),    64'd0);
      tick();
      chk("t5_rst_hold_prod", 64'(prod), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("t5_ready", 64'(ready_o), 64'd1);
      cnt = 0;
      repeat (8) begin
         tick();
         if (valid_o) cnt++;
      end
      chk("t5_no_valid", 64'(cnt), 64'd0);

      // 6: WIDTH=32 all-ones
      w32_a = 32'hFFFFFFFF; w32_b = 32'hFFFFFFFF; w32_valid = 1'b1;
      tick();
      w32_valid = 1'b0;
      n = 0;
      busy_cnt = 0;
      while (!w32_valid_o && n < 60) begin
         if (w32_busy) busy_cnt++;
         tick();
         n++;
      end
      chk("t6_lat",  64'(n),        64'd16);
      chk("t6_busy", 64'(busy_cnt), 64'd16);
      chk("t6_prod", w32_prod,      64'hFFFFFFFE00000001);
      chk("t6_busy_done", 64'(w32_busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/math_multiplier_wallace_seq_ctrl.md
Name: math_multiplier_wallace_seq_ctrl

Overview:
Sequential wide unsigned multiplier controller that time-shares one 8x8 Wallace-tree multiplier core.
- Splits WIDTH-bit operands into 8-bit digits and issues one digit-pair product per cycle to the core.
- Shifts and accumulates each product into a 2*WIDTH-bit result.
- Sits between a valid/ready producer and a valid/ready consumer, as the area-optimised alternative to a full-width combinational tree.

Parameters:
- WIDTH, 16, operand width; must be a multiple of 8 and at least 16. Elaboration error otherwise.
- K, WIDTH/8, derived localparam: digits per operand. Not user-set.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_clear  input  1  synchronous abort; returns to IDLE
- i_valid  input  1  operand pair valid
- o_ready  output  1  controller can accept operands
- i_multiplier  input  WIDTH  operand A, unsigned
- i_multiplicand  input  WIDTH  operand B, unsigned
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_product  output  2*WIDTH  A*B
- o_busy  output  1  high in MUL state

Behaviour:
Interface decision: one clock, i_clk; reset i_rst_n is asynchronous, active-low.

Reset:
- State goes to IDLE.
- o_valid=0, o_busy=0, o_product=0.
- Operand registers, accumulator and digit counters all 0.
- o_ready=1 after reset deasserts.

FSM states: IDLE, MUL, DONE.
- o_ready = (IDLE) or (DONE and i_ready).
- Accept happens on an edge where i_valid and o_ready are both high.

On accept:
- Register both operands and clear the accumulator to 0.
- Set digit counters i=0 (A digit), j=0 (B digit).
- Go to MUL.

MUL (exactly K*K cycles):
- Core inputs are A[8i+7:8i] and B[8j+7:8j].
- Each edge: acc += core_product << 8*(i+j), truncated to 2*WIDTH bits (the true product never overflows).
- j increments; when j wraps K-1 -> 0, i increments.
- On the edge with i=j=K-1, go to DONE.

DONE:
- o_valid=1 and o_product=acc.
- While i_ready=0, o_product and o_valid are held stable, with no change however i_valid or the operands toggle.
- Edge with i_ready=1 and i_valid=0: go to IDLE, o_valid=0.
- Edge with i_ready=1 and i_valid=1: result handed off and new operands accepted on the same edge; go straight to MUL (back-to-back).

Latency and throughput:
- o_valid is visible in the cycle after the (K*K)th edge following the accept edge: 4 cycles for WIDTH=16, 16 for WIDTH=32.
- Back-to-back throughput is one result per K*K+1 cycles.

Other rules:
- o_product is driven only from acc; it shows 0 in IDLE after reset or clear, and its previous value after a normal consume.
- In MUL, o_valid=0 and o_ready=0; operand inputs are ignored.
- i_clear is sampled every edge and has priority over every handshake.
  - It forces IDLE, o_valid=0, acc=0 and counters=0.
  - An accept and a clear on the same edge means the clear wins and the operands are dropped.
  - A result that is pending in DONE is discarded.
- Async reset mid-MUL or mid-DONE drops to the reset values immediately; no partial result escapes.
- Zero operands run the full K*K cycles; there is no early termination.

Decomposition:
Package math_mul_seq_pkg holds:
- enum typedef mul_state_t {IDLE, MUL, DONE}
- localparam DIGIT_W=8
- function for digit-select shift amount

The one natural sub-module is a single instance of math_multiplier_wallace_tree_csa_008 (8x8 -> 16 combinational core), with ports:
- i_multiplier: A digit
- i_multiplicand: B digit
- ow_product: product feeding the accumulator adder

The accumulator adder and counters stay in the top level.

Test Plan:
1. WIDTH=16; A=0x1234, B=0x5678, i_ready=1 -> o_valid rises 4 cycles after accept; o_product=0x06260060 for exactly one cycle; o_ready=1 the same cycle.
2. WIDTH=16; A=B=0xFFFF, i_ready held 0 for 10 cycles, then 1 -> o_product=0xFFFE0001 stable throughout; operand inputs toggled during the wait have no effect; returns to IDLE.
3. Back-to-back: in DONE, i_valid=1 and i_ready=1 with A=3, B=5 following 0x00FF*0x0100 -> first result 0x0000FF00 consumed; 15 (0x0000000F) appears exactly K*K+1 cycles later.
4. i_clear asserted in the 2nd MUL cycle of 0xABCD*0x1111 -> next cycle IDLE, o_valid=0, o_product=0; a new 2*3 request then returns 6.
5. i_rst_n pulsed low mid-MUL -> all outputs are reset values while reset is low; o_ready=1 after release; no o_valid.
6. WIDTH=32; A=B=0xFFFFFFFF -> o_product=0xFFFFFFFE00000001, o_valid after 16 cycles; o_busy high for exactly 16 cycles.
